// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue side: 4-bit opcode constants,
// instruction byte field positions and the sequencer state encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

    // Opcodes carried in instruction byte bits [7:4]
    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ADD     = 4'h1;
    localparam logic [3:0] OP_SUB     = 4'h2;
    localparam logic [3:0] OP_SHL     = 4'h3;
    localparam logic [3:0] OP_SHR     = 4'h4;
    localparam logic [3:0] OP_AND     = 4'h5;
    localparam logic [3:0] OP_OR      = 4'h6;
    localparam logic [3:0] OP_XOR     = 4'h7;
    localparam logic [3:0] OP_NOT     = 4'h8;
    localparam logic [3:0] OP_ILLEGAL = 4'h9;
    localparam logic [3:0] OP_LOAD    = 4'hA;
    localparam logic [3:0] OP_LT      = 4'hB;
    localparam logic [3:0] OP_EQ      = 4'hC;
    localparam logic [3:0] OP_GT      = 4'hD;
    localparam logic [3:0] OP_LDI     = 4'hE;
    localparam logic [3:0] OP_OUT     = 4'hF;

    // Instruction byte field positions
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int DST_BIT = 3;
    localparam int SEL_BIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IMM  = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Issue side of the 8-bit ALU. Accepts instruction bytes on a valid/ready
// handshake, keeps a two-entry register file (A, B), drives the ALU for one
// cycle per operation and writes the registered ALU result back one cycle
// later. OUT copies a register to out_data with a one-cycle out_valid strobe.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   instr_valid/ready  instruction byte handshake
//   instr_data         instruction byte or LDI immediate
//   alu_a, alu_b       ALU operands (follow reg_a / reg_b)
//   alu_op             ALU function, non-zero only in EXEC
//   alu_operand        NOT/shift operand select (0=A, 1=B), EXEC only
//   alu_y              registered ALU result
//   reg_a, reg_b       current register values
//   out_valid/out_data OUT readout
//   err                sticky illegal-opcode flag
// ---------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
#(
    parameter logic [7:0] RESET_A = 8'h00,
    parameter logic [7:0] RESET_B = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [7:0] instr_data,
    output logic       instr_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_operand,
    input  logic [7:0] alu_y,
    output logic [7:0] reg_a,
    output logic [7:0] reg_b,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       err
);

    seq_state_t state_q, state_d;

    logic [7:0] reg_a_q, reg_b_q;
    logic [3:0] opc_q;
    logic       dst_q;
    logic       sel_q;

    logic [3:0] opc_in;
    logic       take;
    logic       load_fields;
    logic       wr_a, wr_b;
    logic [7:0] wr_data;
    logic       out_load;
    logic       err_set;

    assign opc_in = instr_data[OPC_MSB:OPC_LSB];

    // Bytes are only taken while waiting for an instruction or an immediate
    assign instr_ready = (state_q == IDLE) || (state_q == IMM);
    assign take        = instr_valid && instr_ready;

    // The ALU sees a function code only during EXEC; WB must present 0
    assign alu_op      = (state_q == EXEC) ? opc_q : OP_NOP;
    assign alu_operand = (state_q == EXEC) ? sel_q : 1'b0;

    assign alu_a = reg_a_q;
    assign alu_b = reg_b_q;
    assign reg_a = reg_a_q;
    assign reg_b = reg_b_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and register-file write selection
    always_comb begin
        state_d     = state_q;
        load_fields = 1'b0;
        wr_a        = 1'b0;
        wr_b        = 1'b0;
        wr_data     = instr_data;
        out_load    = 1'b0;
        err_set     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    case (opc_in)
                        OP_NOP: ;
                        OP_ILLEGAL: err_set = 1'b1;
                        OP_OUT: out_load = 1'b1;
                        OP_LDI: begin
                            load_fields = 1'b1;
                            state_d     = IMM;
                        end
                        default: begin
                            load_fields = 1'b1;
                            state_d     = EXEC;
                        end
                    endcase
                end
            end
            IMM: begin
                if (take) begin
                    wr_data = instr_data;
                    wr_a    = !dst_q;
                    wr_b    = dst_q;
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                wr_data = alu_y;
                wr_a    = !dst_q;
                wr_b    = dst_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latched instruction fields, held through IMM/EXEC/WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q <= OP_NOP;
            dst_q <= 1'b0;
            sel_q <= 1'b0;
        end else if (load_fields) begin
            opc_q <= opc_in;
            dst_q <= instr_data[DST_BIT];
            sel_q <= instr_data[SEL_BIT];
        end
    end

    // Two-entry register file; writes only at the end of IMM or WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a_q <= RESET_A;
            reg_b_q <= RESET_B;
        end else begin
            if (wr_a) reg_a_q <= wr_data;
            if (wr_b) reg_b_q <= wr_data;
        end
    end

    // OUT readout: strobe for one cycle, data held until the next OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            out_valid <= out_load;
            if (out_load) begin
                out_data <= instr_data[DST_BIT] ? reg_b_q : reg_a_q;
            end
        end
    end

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer with a small registered ALU model on the
// alu_y input. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic       alu_operand;
    logic [7:0] alu_y;
    logic [7:0] reg_a, reg_b;
    logic       out_valid;
    logic [7:0] out_data;
    logic       err;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.RESET_A(8'h00), .RESET_B(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_operand (alu_operand),
        .alu_y       (alu_y),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU model driven by the sequencer's ALU outputs
    always @(posedge clk) begin
        logic [7:0] opnd;
        opnd = alu_operand ? alu_b : alu_a;
        case (alu_op)
            4'h1: alu_y <= alu_a + alu_b;
            4'h2: alu_y <= alu_a - alu_b;
            4'h3: alu_y <= opnd << 1;
            4'h4: alu_y <= opnd >> 1;
            4'h5: alu_y <= alu_a & alu_b;
            4'h6: alu_y <= alu_a | alu_b;
            4'h7: alu_y <= alu_a ^ alu_b;
            4'h8: alu_y <= ~opnd;
            4'hA: alu_y <= alu_b;
            4'hB: alu_y <= (alu_a < alu_b) ? 8'h01 : 8'h00;
            4'hC: alu_y <= (alu_a == alu_b) ? 8'h01 : 8'h00;
            4'hD: alu_y <= (alu_a > alu_b) ? 8'h01 : 8'h00;
            default: alu_y <= alu_y;
        endcase
    end

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and return 1 unit after the edge that transferred it
    task automatic apply_stimulus(input logic [7:0] b);
        bit done;
        done        = 1'b0;
        instr_valid = 1'b1;
        instr_data  = b;
        for (int i = 0; i < 20 && !done; i++) begin
            if (instr_ready) done = 1'b1;
            step();
        end
        instr_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: byte %h never accepted", b);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = 8'h00;
        #1;

        // 1. reset state
        check_output("rst_reg_a", reg_a, 8'h00);
        check_output("rst_reg_b", reg_b, 8'h00);
        check_output("rst_ready", {7'd0, instr_ready}, 8'h01);
        check_output("rst_alu_op", {4'd0, alu_op}, 8'h00);
        check_output("rst_alu_operand", {7'd0, alu_operand}, 8'h00);
        check_output("rst_err", {7'd0, err}, 8'h00);
        check_output("rst_out_valid", {7'd0, out_valid}, 8'h00);
        check_output("rst_out_data", out_data, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 2. LDI A=5, LDI B=3, ADD into A, OUT A
        apply_stimulus(8'hE0);
        apply_stimulus(8'h05);
        check_output("ldi_a", reg_a, 8'h05);
        apply_stimulus(8'hE8);
        apply_stimulus(8'h03);
        check_output("ldi_b", reg_b, 8'h03);
        apply_stimulus(8'h10);
        check_output("add_exec_op", {4'd0, alu_op}, 8'h01);
        check_output("add_exec_a", alu_a, 8'h05);
        check_output("add_exec_b", alu_b, 8'h03);
        step();
        check_output("add_wb_op", {4'd0, alu_op}, 8'h00);
        check_output("add_wb_ready", {7'd0, instr_ready}, 8'h00);
        step();
        check_output("add_result", reg_a, 8'h08);
        check_output("add_idle_ready", {7'd0, instr_ready}, 8'h01);
        apply_stimulus(8'hF0);
        check_output("out_valid_hi", {7'd0, out_valid}, 8'h01);
        check_output("out_data", out_data, 8'h08);
        step();
        check_output("out_valid_lo", {7'd0, out_valid}, 8'h00);
        check_output("out_data_hold", out_data, 8'h08);

        // 3. A=2, B=5, SUB into B -> 0xFD
        apply_stimulus(8'hE0);
        apply_stimulus(8'h02);
        apply_stimulus(8'hE8);
        apply_stimulus(8'h05);
        apply_stimulus(8'h28);
        check_output("sub_exec_ready", {7'd0, instr_ready}, 8'h00);
        check_output("sub_exec_op", {4'd0, alu_op}, 8'h02);
        step();
        check_output("sub_wb_ready", {7'd0, instr_ready}, 8'h00);
        step();
        check_output("sub_idle_ready", {7'd0, instr_ready}, 8'h01);
        check_output("sub_result", reg_b, 8'hFD);

        // 4. B=0x0F, NOT B into A -> 0xF0; EQ into B -> 0x00
        apply_stimulus(8'hE8);
        apply_stimulus(8'h0F);
        apply_stimulus(8'h84);
        check_output("not_exec_sel", {7'd0, alu_operand}, 8'h01);
        check_output("not_exec_op", {4'd0, alu_op}, 8'h08);
        step();
        check_output("not_wb_sel", {7'd0, alu_operand}, 8'h00);
        step();
        check_output("not_result", reg_a, 8'hF0);
        apply_stimulus(8'hC8);
        step();
        step();
        check_output("eq_result", reg_b, 8'h00);
        check_output("eq_keep_a", reg_a, 8'hF0);

        // 5. illegal opcode then NOP, back-to-back
        apply_stimulus(8'h90);
        check_output("ill_err", {7'd0, err}, 8'h01);
        check_output("ill_ready", {7'd0, instr_ready}, 8'h01);
        check_output("ill_keep_a", reg_a, 8'hF0);
        apply_stimulus(8'h00);
        check_output("nop_ready", {7'd0, instr_ready}, 8'h01);
        check_output("nop_keep_a", reg_a, 8'hF0);
        check_output("nop_keep_b", reg_b, 8'h00);
        check_output("nop_err", {7'd0, err}, 8'h01);
        apply_stimulus(8'hE0);
        apply_stimulus(8'h01);
        apply_stimulus(8'h18);
        step();
        step();
        check_output("add_b_result", reg_b, 8'h01);
        check_output("err_sticky", {7'd0, err}, 8'h01);

        // 6. reset during WB aborts the writeback
        apply_stimulus(8'hE0);
        apply_stimulus(8'h03);
        apply_stimulus(8'hE8);
        apply_stimulus(8'h04);
        apply_stimulus(8'h10);
        step();
        check_output("pre_rst_wb_op", {4'd0, alu_op}, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_a", reg_a, 8'h00);
        check_output("async_rst_b", reg_b, 8'h00);
        check_output("async_rst_err", {7'd0, err}, 8'h00);
        check_output("async_rst_ready", {7'd0, instr_ready}, 8'h01);
        step();
        rst_n = 1'b1;
        step();
        check_output("no_writeback_a", reg_a, 8'h00);

        // instr_valid held through EXEC/WB transfers only once back in IDLE
        apply_stimulus(8'hE0);
        apply_stimulus(8'h06);
        apply_stimulus(8'hE8);
        apply_stimulus(8'h07);
        check_output("post_rst_ldi", reg_b, 8'h07);
        apply_stimulus(8'h18);
        instr_valid = 1'b1;
        instr_data  = 8'hF8;
        step();
        check_output("held_wb_out_valid", {7'd0, out_valid}, 8'h00);
        step();
        check_output("held_idle_out_valid", {7'd0, out_valid}, 8'h00);
        check_output("held_add_result", reg_b, 8'h0D);
        step();
        instr_valid = 1'b0;
        check_output("held_out_valid", {7'd0, out_valid}, 8'h01);
        check_output("held_out_data", out_data, 8'h0D);
        step();
        check_output("held_out_single", {7'd0, out_valid}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issue side of the 8-bit ALU interface. Accepts byte-wide instructions over a valid/ready handshake and holds a two-entry register file (A, B). Drives the ALU operand, opcode and operand-select inputs for exactly one cycle per operation, captures the registered ALU result one cycle later, and writes it back. Sits between the instruction source (pins or a fetch unit) and the ALU; also provides an OUT path for register readout.

Parameters:
RESET_A, 8'h00, value loaded into register A on reset
RESET_B, 8'h00, value loaded into register B on reset

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
instr_valid  in  1  instruction byte present on instr_data
instr_data  in  8  instruction byte or LDI immediate
instr_ready  out  1  sequencer accepts a byte this cycle
alu_a  out  8  ALU operand A (= register A)
alu_b  out  8  ALU operand B (= register B)
alu_op  out  4  ALU function select
alu_operand  out  1  ALU operand select for NOT/shift (0=A, 1=B)
alu_y  in  8  registered ALU result
reg_a  out  8  current register A
reg_b  out  8  current register B
out_valid  out  1  one-cycle strobe, out_data valid
out_data  out  8  register value from OUT
err  out  1  sticky illegal-opcode flag

Behaviour:
- One clock domain (clk); reset is asynchronous, active-low (rst_n). All state and outputs clear on assertion, independent of clk.
- Reset values: reg_a=RESET_A, reg_b=RESET_B, state IDLE, instr_ready=1, alu_op=0, alu_operand=0, out_valid=0, out_data=0, err=0.
- Instruction byte: [7:4] opcode, [3] dst (0=A, 1=B), [2] operand select, [1:0] ignored.
- Opcodes: 0x0 NOP; 0x1 ADD; 0x2 SUB; 0x3 SHL; 0x4 SHR; 0x5 AND; 0x6 OR; 0x7 XOR; 0x8 NOT; 0xA LOAD (B); 0xB LT; 0xC EQ; 0xD GT; 0xE LDI (two-byte); 0xF OUT; 0x9 illegal.
- A byte transfers on a posedge with instr_valid & instr_ready.
- States:
  - IDLE: ready=1. ALU op -> EXEC. LDI -> IMM. OUT -> out_data<=reg[dst], out_valid=1 next cycle, stay IDLE. NOP -> stay IDLE. 0x9 -> err<=1, stay IDLE.
  - IMM: ready=1. Accepted byte is written to reg[dst] -> IDLE. Holds indefinitely while instr_valid=0.
  - EXEC: ready=0. alu_op=latched opcode, alu_operand=latched bit[2]. The ALU registers its result at the end of this cycle -> WB.
  - WB: ready=0, alu_op=0. reg[dst]<=alu_y at the end of the cycle -> IDLE.
- alu_op is 0 in every state except EXEC.
- alu_a/alu_b follow reg_a/reg_b continuously. Registers change only at the end of IMM or WB, so operands are stable through EXEC.
- Throughput:
  - ALU op: 3 cycles (accept, EXEC, WB). The next byte is accepted in the cycle after WB.
  - LDI: 2 accepted bytes.
  - OUT/NOP/illegal: 1 cycle, back-to-back.
- Arithmetic is 8-bit modulo inside the ALU; no carry is kept.
- out_valid is high for exactly one cycle per OUT. out_data holds its value until the next OUT.
- err clears only on reset.
- Reset during EXEC/WB/IMM aborts the operation: no writeback, state returns to IDLE. The ALU resets synchronously, so rst_n must be held across at least one clk edge.
- instr_valid held while ready=0 does not transfer; the source keeps the byte until ready.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit opcode constants OP_NOP..OP_GT, OP_LDI=4'hE, OP_OUT=4'hF, OP_ILLEGAL=4'h9.
  - Instruction field positions.
  - State enum {IDLE, IMM, EXEC, WB}.
- No sub-module: the two-entry register file and FSM are inline (~150–250 lines).

Test Plan:
1. Reset -> reg_a=reg_b=0x00, instr_ready=1, alu_op=0, err=0, out_valid=0; assert rst_n=0 between clk edges -> outputs clear immediately.
2. Bytes 0xE0,0x05,0xE8,0x03,0x10,0xF0 -> reg_a=0x05, reg_b=0x03; then alu_op=1 for exactly one cycle; reg_a=0x08 at the end of WB; out_valid single pulse with out_data=0x08.
3. A=0x02, B=0x05, byte 0x28 (SUB, dst B) -> reg_b=0xFD; instr_ready low exactly during EXEC and WB.
4. B=0x0F, byte 0x84 (NOT, dst A, operand B) -> alu_operand=1 during EXEC, reg_a=0xF0. Then byte 0xC8 (EQ, dst B) with A=0xF0, B=0x0F -> reg_b=0x00.
5. Byte 0x90 -> err=1 and sticks through subsequent ops, registers unchanged. Byte 0x00 -> no state change; both accepted back-to-back.
6. Reset pulse during WB of ADD -> no writeback, regs return to RESET_A/RESET_B, next byte accepted in IDLE. Also, instr_valid held through EXEC is accepted only after WB completes.
